// File: rtl/epbuf_pkg.sv
// rtl/epbuf_pkg.sv - shared constants for the EP-buffer two-port arbiter
//
// Purpose: FSM state encodings and port index constants used by
//          epbuf_arbiter and arb_rr2.
// Ports:   none (package)

package epbuf_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    // Port indices: port 0 is the CPU bus, port 1 the E1 data mover
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

endpackage : epbuf_pkg

// File: rtl/epbuf_arbiter_arb_rr2.sv
// rtl/epbuf_arbiter_arb_rr2.sv - two-requester round-robin picker
//
// Purpose: combinationally selects one of two requesters. A lone requester
//          always wins; on a tie the requester named by prio wins.
// Ports:
//   req   in  2  request vector, bit i = port i requesting
//   prio  in  1  port preferred on a tie
//   grant out 1  index of the winning port (PORT_CPU when nobody requests)

module arb_rr2
    import epbuf_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic       grant
);

    always_comb begin
        grant = PORT_CPU;
        case (req)
            2'b01:   grant = PORT_CPU;
            2'b10:   grant = PORT_DMA;
            2'b11:   grant = prio;
            default: grant = PORT_CPU;
        endcase
    end

endmodule : arb_rr2

// File: rtl/epbuf_arbiter.sv
// rtl/epbuf_arbiter.sv - round-robin share of one EP-buffer port between two Wishbone slaves
//
// Purpose: arbitrates single-word transfers from m0 (CPU) and m1 (E1 data
//          mover) onto the USB endpoint buffer. Each transfer is sequenced
//          IDLE (grant) -> ACCESS (EP strobe) -> ACK (one-cycle ack).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   m0_* / m1_*                Wishbone classic slave ports: addr, wdata, we,
//                              cyc in; rdata, ack out
//   ep_tx_addr_0/data_0/we_0   EP buffer write port
//   ep_rx_addr_0/re_0          EP buffer read address / enable
//   ep_rx_data_1               EP read data, one cycle after address

module epbuf_arbiter
    import epbuf_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic [AW-1:0] m0_addr,
    output logic [DW-1:0] m0_rdata,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m0_we,
    input  logic          m0_cyc,
    output logic          m0_ack,

    input  logic [AW-1:0] m1_addr,
    output logic [DW-1:0] m1_rdata,
    input  logic [DW-1:0] m1_wdata,
    input  logic          m1_we,
    input  logic          m1_cyc,
    output logic          m1_ack,

    output logic [AW-1:0] ep_tx_addr_0,
    output logic [DW-1:0] ep_tx_data_0,
    output logic          ep_tx_we_0,
    output logic [AW-1:0] ep_rx_addr_0,
    input  logic [DW-1:0] ep_rx_data_1,
    output logic          ep_rx_re_0
);

    logic [1:0]    state;
    logic          sel;
    logic          prio;
    logic          grant;

    logic          cyc_sel;
    logic          we_sel;
    logic [AW-1:0] addr_sel;
    logic [DW-1:0] wdata_sel;

    logic          in_access;
    logic          in_ack;

    arb_rr2 u_arb (
        .req   ({m1_cyc, m0_cyc}),
        .prio  (prio),
        .grant (grant)
    );

    // Selected-master mux; only sel matters, so the non-selected master's
    // inputs are invisible until the FSM is back in IDLE.
    always_comb begin
        cyc_sel   = m0_cyc;
        we_sel    = m0_we;
        addr_sel  = m0_addr;
        wdata_sel = m0_wdata;
        if (sel == PORT_DMA) begin
            cyc_sel   = m1_cyc;
            we_sel    = m1_we;
            addr_sel  = m1_addr;
            wdata_sel = m1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            sel   <= PORT_CPU;
            prio  <= PORT_CPU;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (m0_cyc || m1_cyc) begin
                        sel   <= grant;
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // A master that dropped cyc here aborts: no strobe, no ack,
                    // and prio stays put since nothing was served.
                    state <= cyc_sel ? ST_ACK : ST_IDLE;
                end
                ST_ACK: begin
                    prio  <= ~sel;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_access = (state == ST_ACCESS);
    assign in_ack    = (state == ST_ACK);

    assign ep_tx_addr_0 = addr_sel;
    assign ep_rx_addr_0 = addr_sel;
    assign ep_tx_data_0 = wdata_sel;

    // we_sel and ~we_sel keep the two strobes mutually exclusive.
    assign ep_tx_we_0 = in_access & cyc_sel &  we_sel;
    assign ep_rx_re_0 = in_access & cyc_sel & ~we_sel;

    // The EP read data arrives in ACK, one cycle after the ACCESS address.
    assign m0_rdata = ep_rx_data_1;
    assign m1_rdata = ep_rx_data_1;

    assign m0_ack = in_ack & (sel == PORT_CPU);
    assign m1_ack = in_ack & (sel == PORT_DMA);

endmodule : epbuf_arbiter
